// File: rtl/pwm_sequencer_pkg.sv
// rtl/pwm_sequencer_pkg.sv - shared state encoding and width default for the PWM sequencer
package pwm_sequencer_pkg;

  localparam int PWM_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pwm_state_e;

endpackage : pwm_sequencer_pkg

// File: rtl/pwm_sequencer_if.sv
// rtl/pwm_sequencer_if.sv - control/status bundle between the PWM sequencer and its driver
interface pwm_sequencer_if #(
  parameter int WIDTH = pwm_sequencer_pkg::PWM_WIDTH_DEFAULT
);

  logic             tick;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] duty_in;
  logic             pwm_out;
  logic             period_done;
  logic             running;

  modport master (
    output tick,
    output en,
    output load,
    output duty_in,
    input  pwm_out,
    input  period_done,
    input  running
  );

  modport slave (
    input  tick,
    input  en,
    input  load,
    input  duty_in,
    output pwm_out,
    output period_done,
    output running
  );

endinterface : pwm_sequencer_if

// File: rtl/pwm_sequencer.sv
// rtl/pwm_sequencer.sv - tick-driven PWM generator with IDLE/RUN/STOP sequencing
// and period-aligned duty updates.
module pwm_sequencer
  import pwm_sequencer_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  pwm_sequencer_if.slave        bus
);

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;
  logic             period_done_q, period_done_d;
  logic             running;
  logic             wrap;

  assign running = (state_q != IDLE);
  assign wrap    = running && bus.tick && (count_q == COUNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A STOP that sees en return resumes RUN even on the wrap tick, so the period is not cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.en) state_d = RUN;
      end
      RUN: begin
        if (!bus.en) state_d = STOP;
      end
      STOP: begin
        if (bus.en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    duty_act_d  = duty_act_q;
    duty_pend_d = bus.load ? bus.duty_in : duty_pend_q;
    if (!running) begin
      count_d = '0;
      if (bus.en) duty_act_d = duty_pend_q;
    end else begin
      if (bus.tick) count_d = count_q + 1'b1;
      // A load landing on the wrap tick goes straight to the active duty.
      if (wrap) duty_act_d = bus.load ? bus.duty_in : duty_pend_q;
    end
  end

  always_comb begin
    pwm_d         = running && (count_q < duty_act_q);
    period_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      duty_pend_q   <= '0;
      duty_act_q    <= '0;
      pwm_q         <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      duty_pend_q   <= duty_pend_d;
      duty_act_q    <= duty_act_d;
      pwm_q         <= pwm_d;
      period_done_q <= period_done_d;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_done = period_done_q;
  assign bus.running     = running;

endmodule : pwm_sequencer

// File: tb/tb_pwm_sequencer.sv
// tb/tb_pwm_sequencer.sv - scoreboard bench: per-period high/length expectations checked on period_done
module tb_pwm_sequencer;

  logic clk;
  logic reset;

  pwm_sequencer_if #(.WIDTH(8)) bus ();

  pwm_sequencer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int high;
    int len;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: accumulate pwm high samples and running samples, compare on each period_done.
  int acc_high = 0;
  int acc_len  = 0;
  logic prev_run = 1'b0;
  int   period_no = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      acc_high = 0;
      acc_len  = 0;
      prev_run = 1'b0;
    end else begin
      if (bus.pwm_out) acc_high++;
      if (prev_run) acc_len++;
      if (bus.period_done) begin
        period_no++;
        if (sb_q.size() == 0) begin
          check($sformatf("unexpected_period_done_%0d", period_no), 1, 0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("period%0d_high", period_no), acc_high, e.high);
          check($sformatf("period%0d_len", period_no), acc_len, e.len);
        end
        acc_high = 0;
        acc_len  = 0;
      end
      prev_run = bus.running;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int high, input int len);
    exp_t e;
    e.high = high;
    e.len  = len;
    sb_q.push_back(e);
  endtask

  // One full 256-tick period starting at count 0; k is the count seen by each edge.
  task automatic run_period(input int high, input int load_k, input int load_val,
                            input int off_k, input int on_k);
    push_exp(high, 256);
    bus.tick = 1'b1;
    for (int k = 0; k < 256; k++) begin
      bus.load    = (k == load_k);
      bus.duty_in = 8'(load_val);
      if (k == off_k) bus.en = 1'b0;
      if (k == on_k)  bus.en = 1'b1;
      if (off_k >= 0 && on_k < 0 && k == 200) check("running_in_stop", int'(bus.running), 1);
      step();
    end
    bus.load = 1'b0;
  endtask

  task automatic idle_load(input int val);
    bus.load    = 1'b1;
    bus.duty_in = 8'(val);
    step();
    bus.load    = 1'b0;
  endtask

  task automatic start_run();
    bus.en = 1'b1;
    step();
  endtask

  initial begin
    reset       = 1'b1;
    bus.tick    = 1'b1;
    bus.en      = 1'b1;
    bus.load    = 1'b1;
    bus.duty_in = 8'd77;
    step();
    step();
    check("reset_pwm", int'(bus.pwm_out), 0);
    check("reset_period_done", int'(bus.period_done), 0);
    check("reset_running", int'(bus.running), 0);
    reset    = 1'b0;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    step();
    check("idle_running", int'(bus.running), 0);

    idle_load(64);
    start_run();
    run_period(64, -1, 0, -1, -1);
    run_period(64, -1, 0, 100, 150);
    run_period(64, 50, 200, -1, -1);
    run_period(200, -1, 0, -1, -1);
    run_period(200, 255, 128, -1, -1);
    run_period(128, -1, 0, -1, -1);
    run_period(128, -1, 0, 100, -1);
    check("after_stop_running", int'(bus.running), 0);
    check("after_stop_pwm", int'(bus.pwm_out), 0);
    for (int i = 0; i < 20; i++) step();
    check("idle_pwm_low", int'(bus.pwm_out), 0);

    idle_load(0);
    start_run();
    run_period(0, -1, 0, -1, -1);
    run_period(0, 10, 255, -1, -1);
    run_period(255, -1, 0, -1, -1);
    run_period(255, 20, 200, -1, -1);
    for (int k = 0; k < 150; k++) step();
    check("pre_reset_running", int'(bus.running), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_pwm", int'(bus.pwm_out), 0);
    check("midreset_period_done", int'(bus.period_done), 0);
    check("midreset_running", int'(bus.running), 0);

    start_run();
    run_period(0, 5, 100, -1, -1);
    run_period(100, -1, 0, 0, -1);
    check("second_stop_running", int'(bus.running), 0);

    idle_load(30);
    start_run();
    bus.en = 1'b0;
    push_exp(60, 512);
    for (int i = 1; i <= 512; i++) begin
      bus.tick = ((i % 2) == 0);
      step();
    end
    bus.tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("half_tick_end_running", int'(bus.running), 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pwm_sequencer

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: counter and duty width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  one-clk-wide clock-enable strobe from the upstream divider stage; advances the PWM counter.
REQ-005 en  input  1  run request; level-sensitive.
REQ-006 duty_in  input  WIDTH  requested duty value.
REQ-007 load  input  1  one-cycle strobe; captures duty_in into the pending register.
REQ-008 pwm_out  output  1  registered PWM output.
REQ-009 period_done  output  1  one-clk pulse on counter wrap.
REQ-010 running  output  1  high in RUN or STOP state.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN, STOP.
REQ-012 IDLE: en=1 -> RUN next cycle; count <= 0; duty_act <= duty_pend; tick ignored.
REQ-013 RUN: on tick, count <= count+1, modulo 2^WIDTH; en=0 -> STOP.
REQ-014 STOP: counting continues on tick; en=1 -> RUN with no count discontinuity; wrap -> IDLE, count <= 0.
REQ-015 Wrap: tick with count = 2^WIDTH-1; period_done=1 for exactly that cycle+1 (registered, one clk).
REQ-016 At wrap, duty_act <= duty_pend; duty_act SHALL NOT change at any other time except on IDLE->RUN.
REQ-017 load and wrap in the same cycle: duty_act <= duty_in directly (bypass); duty_pend <= duty_in.
REQ-018 load in any state updates duty_pend only (except REQ-017).
REQ-019 pwm_out <= running && (count < duty_act), evaluated every clk; one-clk latency from count.
REQ-020 duty_act=0: pwm_out constantly 0; duty_act=2^WIDTH-1: high for 2^WIDTH-1 of 2^WIDTH ticks.
REQ-021 tick held high continuously SHALL advance count every clk (no edge detection).
REQ-022 period_done SHALL NOT assert in IDLE.

Reset
REQ-023 reset=1 at any clk edge, including mid-period: state <= IDLE, count <= 0, duty_pend <= 0, duty_act <= 0, pwm_out <= 0, period_done <= 0, running <= 0.
REQ-024 reset SHALL take priority over en, tick and load in the same cycle.

Structure
REQ-025 The shared package SHALL hold the state enum (IDLE, RUN, STOP) and the WIDTH default constant.
REQ-026 Implementation SHALL be a single module with no sub-modules; the upstream divider supplies tick.

Verification
REQ-027 load duty_in=64, en=1, tick every clk -> pwm_out high 64 clks, low 192 clks per period; period_done every 256 clks.
REQ-028 During RUN with duty 64, load 200 mid-period -> current period keeps 64; next period after period_done shows 200 high.
REQ-029 load 128 in the exact wrap cycle -> following period 128 high (bypass).
REQ-030 en=0 at count=100 -> running stays 1 until wrap, period_done pulses, then IDLE, pwm_out=0, count=0.
REQ-031 reset=1 at count=150, duty 200 -> next cycle all outputs 0, IDLE; en=1 restarts with duty_act=0 until load+wrap.
REQ-032 duty 0 and duty 255 over two periods -> pwm_out always 0; pwm_out low exactly 1 tick per period.
